pc_call_stack: RTL and testbench

- Consumer side of the control unit's flow-control outputs (pc_en, mux_pc_branch, call, ret).
- Holds the program counter and a hardware return-address stack (LIFO).
- Each enabled cycle it selects the next PC: increment, branch, call (push + jump) or return (pop).
- Drives the instruction-memory address and reports stack status and sticky error flags.

---
 rtl/cpu_pkg.sv | 5 +
 rtl/ret_stack.sv | 38 +++
 rtl/pc_call_stack.sv | 62 ++++++
 tb/tb_pc_call_stack.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared address width and next-pc selector encoding
package cpu_pkg;
  localparam int ADDR_W = 8;
  typedef enum logic [2:0] {PC_INC, PC_BRANCH, PC_CALL, PC_RET, PC_HOLD} pc_sel_t;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: DEPTH x ADDR_W return-address LIFO; push ignored when full, pop ignored when empty
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int ADDR_W = 8,
  localparam int SPW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic [SPW-1:0]    sp,
  output logic              full,
  output logic              empty
);
  localparam int IW = $clog2(DEPTH);
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d, top;
  logic do_push, do_pop;
  assign empty = sp_q == '0;
  assign full = sp_q == SPW'(DEPTH);
  assign top = sp_q - SPW'(1);
  assign dout = empty ? '0 : mem_q[top[IW-1:0]];
  assign sp = sp_q;
  assign do_pop = pop & ~empty;
  assign do_push = push & ~full & ~do_pop;
  always_comb sp_d = do_pop ? top : do_push ? sp_q + SPW'(1) : sp_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q <= sp_d;
      if (do_push) mem_q[sp_q[IW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/pc_call_stack.sv
// pc_call_stack: program counter with call/return stack, priority ret > call > branch > increment
module pc_call_stack #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH = 8,
  localparam int SPW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic              mux_pc_branch,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [SPW-1:0]    sp,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stk_ovf,
  output logic              stk_unf
);
  import cpu_pkg::*;
  pc_sel_t sel;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, top;
  logic ovf_q, ovf_d, unf_q, unf_d;
  ret_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_stack (
    .clk(clk),
    .rst(rst),
    .push(sel == PC_CALL),
    .pop(sel == PC_RET),
    .din(pc_inc),
    .dout(top),
    .sp(sp),
    .full(stack_full),
    .empty(stack_empty)
  );
  assign pc_inc = pc_q + ADDR_W'(1);
  always_comb begin
    sel = !pc_en ? PC_HOLD :
          ret ? (stack_empty ? PC_INC : PC_RET) :
          call ? (stack_full ? PC_INC : PC_CALL) :
          mux_pc_branch ? PC_BRANCH : PC_INC;
    pc_d = sel == PC_RET ? top :
           (sel == PC_CALL || sel == PC_BRANCH) ? branch_target :
           sel == PC_HOLD ? pc_q : pc_inc;
    ovf_d = ovf_q | (pc_en & ~ret & call & stack_full);
    unf_d = unf_q | (pc_en & ret & stack_empty);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign pc = pc_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: table vectors plus hand sequences, expected values queued and checked after each edge
module tb_pc_call_stack;
  logic clk = 1'b0;
  logic rst, pc_en, mux_pc_branch, call, ret;
  logic [7:0] branch_target, pc;
  logic [3:0] sp;
  logic stack_empty, stack_full, stk_ovf, stk_unf;
  always #5 clk = ~clk;
  pc_call_stack #(.ADDR_W(8), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .pc_en(pc_en),
    .mux_pc_branch(mux_pc_branch),
    .call(call),
    .ret(ret),
    .branch_target(branch_target),
    .pc(pc),
    .sp(sp),
    .stack_empty(stack_empty),
    .stack_full(stack_full),
    .stk_ovf(stk_ovf),
    .stk_unf(stk_unf)
  );
  typedef struct {
    logic r, e, b, c, t;
    logic [7:0] tgt, epc;
    logic [3:0] esp;
    logic eo, eu;
    string name;
  } vec_t;
  typedef struct {
    logic [7:0] pc;
    logic [3:0] sp;
    logic ovf, unf;
    string name;
  } exp_t;
  exp_t sb[$];
  vec_t vt[$];
  int checks = 0;
  int failures = 0;
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask
  task automatic drive(input logic r, e, b, c, t, input logic [7:0] tgt, input logic [7:0] epc,
                       input logic [3:0] esp, input logic eo, eu, input string n);
    exp_t x;
    rst = r;
    pc_en = e;
    mux_pc_branch = b;
    call = c;
    ret = t;
    branch_target = tgt;
    sb.push_back('{epc, esp, eo, eu, n});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.name, ".pc"}, pc, x.pc);
    chk({x.name, ".sp"}, {4'h0, sp}, {4'h0, x.sp});
    chk({x.name, ".empty"}, {7'h0, stack_empty}, {7'h0, x.sp == 4'd0});
    chk({x.name, ".full"}, {7'h0, stack_full}, {7'h0, x.sp == 4'd8});
    chk({x.name, ".ovf"}, {7'h0, stk_ovf}, {7'h0, x.ovf});
    chk({x.name, ".unf"}, {7'h0, stk_unf}, {7'h0, x.unf});
  endtask
  function automatic vec_t v(input logic r, e, b, c, t, input logic [7:0] tgt, epc,
                             input logic [3:0] esp, input logic eo, eu, input string n);
    v = '{r, e, b, c, t, tgt, epc, esp, eo, eu, n};
  endfunction
  initial begin
    logic [7:0] p, tg;
    logic [7:0] ra [8];
    vt.push_back(v(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, "rst0"));
    vt.push_back(v(0, 1, 1, 1, 0, 8'h55, 8'h00, 0, 0, 0, "rst1"));
    vt.push_back(v(1, 1, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, "inc1"));
    vt.push_back(v(1, 1, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0, "inc2"));
    vt.push_back(v(1, 1, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0, "inc3"));
    vt.push_back(v(1, 1, 0, 0, 0, 8'h00, 8'h04, 0, 0, 0, "inc4"));
    vt.push_back(v(1, 1, 0, 0, 0, 8'h00, 8'h05, 0, 0, 0, "inc5"));
    vt.push_back(v(1, 1, 1, 0, 0, 8'h40, 8'h40, 0, 0, 0, "br40"));
    vt.push_back(v(1, 0, 1, 1, 0, 8'h99, 8'h40, 0, 0, 0, "stall1"));
    vt.push_back(v(1, 0, 0, 0, 1, 8'h99, 8'h40, 0, 0, 0, "stall2"));
    vt.push_back(v(1, 0, 1, 0, 0, 8'h99, 8'h40, 0, 0, 0, "stall3"));
    vt.push_back(v(1, 1, 1, 0, 0, 8'h10, 8'h10, 0, 0, 0, "br10"));
    vt.push_back(v(1, 1, 1, 1, 0, 8'h80, 8'h80, 1, 0, 0, "call80"));
    vt.push_back(v(1, 1, 0, 1, 0, 8'hC0, 8'hC0, 2, 0, 0, "callC0"));
    vt.push_back(v(1, 0, 0, 0, 1, 8'h00, 8'hC0, 2, 0, 0, "stall_ret"));
    vt.push_back(v(1, 1, 0, 0, 1, 8'h00, 8'h81, 1, 0, 0, "ret81"));
    vt.push_back(v(1, 1, 1, 0, 1, 8'h77, 8'h11, 0, 0, 0, "ret11"));
    vt.push_back(v(1, 1, 1, 0, 0, 8'h50, 8'h50, 0, 0, 0, "br50"));
    for (int i = 0; i < vt.size(); i++)
      drive(vt[i].r, vt[i].e, vt[i].b, vt[i].c, vt[i].t, vt[i].tgt, vt[i].epc, vt[i].esp,
            vt[i].eo, vt[i].eu, vt[i].name);
    p = 8'h50;
    for (int i = 0; i < 8; i++) begin
      tg = (i == 7) ? 8'h90 : 8'h60 + 8'(8 * i);
      ra[i] = p + 8'h01;
      drive(1, 1, 0, 1, 0, tg, tg, 4'(i + 1), 0, 0, "fill");
      p = tg;
    end
    drive(1, 1, 0, 1, 0, 8'h20, 8'h91, 8, 1, 0, "call_full");
    for (int j = 0; j < 8; j++)
      drive(1, 1, 0, 0, 1, 8'h00, ra[7 - j], 4'(7 - j), 1, 0, "unwind");
    drive(1, 1, 1, 0, 0, 8'h33, 8'h33, 0, 1, 0, "br33");
    drive(1, 1, 0, 0, 1, 8'h00, 8'h34, 0, 1, 1, "ret_empty");
    drive(1, 1, 1, 0, 0, 8'hFF, 8'hFF, 0, 1, 1, "brFF");
    drive(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 1, "inc_wrap");
    drive(1, 1, 1, 0, 0, 8'hFF, 8'hFF, 0, 1, 1, "brFF2");
    drive(1, 1, 0, 1, 0, 8'h05, 8'h05, 1, 1, 1, "call_wrap");
    drive(1, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 1, "ret_wrap");
    drive(1, 1, 1, 0, 0, 8'h21, 8'h21, 0, 1, 1, "br21");
    drive(1, 1, 0, 1, 0, 8'h70, 8'h70, 1, 1, 1, "call70");
    drive(1, 1, 0, 1, 1, 8'h99, 8'h22, 0, 1, 1, "call_and_ret");
    drive(1, 1, 0, 1, 0, 8'hA0, 8'hA0, 1, 1, 1, "callA0");
    drive(1, 1, 0, 1, 0, 8'hB0, 8'hB0, 2, 1, 1, "callB0");
    drive(1, 1, 0, 1, 0, 8'hC0, 8'hC0, 3, 1, 1, "callC0b");
    drive(0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, "rst_mid");
    drive(1, 1, 0, 0, 1, 8'h00, 8'h01, 0, 0, 1, "ret_after_rst");
    drive(1, 1, 0, 1, 0, 8'h44, 8'h44, 1, 0, 1, "call44");
    drive(1, 1, 0, 0, 1, 8'h00, 8'h02, 0, 0, 1, "ret02");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
